// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the program-image loader.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package mem_loader_pkg;

  localparam int LEN_BYTES = 4;
  localparam int CSUM_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Word-wide memory write bus between the loader (master) and the arbiter/memory (slave).
interface mem_loader_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  sel;
  logic        we;

  modport master (output req, addr, data, sel, we, input gnt);
  modport slave  (input req, addr, data, sel, we, output gnt);
endinterface

// File: rtl/mem_loader.sv
// Streams a length-prefixed byte image into memory as little-endian masked word writes.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_BYTES = 16384
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic         rx_ready_o,
  mem_loader_if.master mem,
  output logic         halt_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  state_t      state;
  logic [31:0] len;
  logic [31:0] byte_cnt;
  logic [29:0] word_idx;
  logic [31:0] data_buf;
  logic [3:0]  sel_buf;
  logic [31:0] addr_q;
  logic        rx_ready;
  logic        req;
  logic        done;
  logic        err;
`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  logic        rx_fire;
  logic [1:0]  lane;
  logic        last_byte;
  logic [31:0] len_full;
  logic [31:0] data_next;
  logic [3:0]  sel_next;

  assign rx_fire   = rx_valid_i & rx_ready;
  assign lane      = byte_cnt[1:0];
  assign last_byte = (byte_cnt + 32'd1) == len;
  // The fourth header byte is the most significant one.
  assign len_full  = {rx_data_i, len[23:0]};

  always_comb begin
    data_next = data_buf;
    sel_next  = sel_buf;
    data_next[{lane, 3'b000} +: 8] = rx_data_i;
    sel_next[lane] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      data_buf <= '0;
      sel_buf  <= '0;
      addr_q   <= '0;
      rx_ready <= 1'b0;
      req      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= LEN;
            rx_ready <= 1'b1;
            len      <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            data_buf <= '0;
            sel_buf  <= '0;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        LEN: begin
          if (rx_fire) begin
            len[{lane, 3'b000} +: 8] <= rx_data_i;
            byte_cnt <= byte_cnt + 32'd1;
            if (byte_cnt == 32'(LEN_BYTES - 1)) begin
              byte_cnt <= '0;
              if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= CSUM;
`else
                state    <= DONE;
                rx_ready <= 1'b0;
                done     <= 1'b1;
`endif
              end else if (len_full > 32'(MAX_BYTES)) begin
                state    <= IDLE;
                rx_ready <= 1'b0;
                err      <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        // Bytes are packed by lane; a word is flushed when full or at end of payload.
        DATA: begin
          if (rx_fire) begin
            data_buf <= data_next;
            sel_buf  <= sel_next;
            byte_cnt <= byte_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum + rx_data_i;
`endif
            if (lane == 2'd3 || last_byte) begin
              state    <= WRITE;
              rx_ready <= 1'b0;
              req      <= 1'b1;
              addr_q   <= BASE_ADDR + {word_idx, 2'b00};
            end
          end
        end

        WRITE: begin
          if (mem.gnt) begin
            req      <= 1'b0;
            word_idx <= word_idx + 30'd1;
            data_buf <= '0;
            sel_buf  <= '0;
            if (byte_cnt < len) begin
              state    <= DATA;
              rx_ready <= 1'b1;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CSUM;
              rx_ready <= 1'b1;
`else
              state    <= DONE;
              done     <= 1'b1;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (rx_fire) begin
            rx_ready <= 1'b0;
            if (rx_data_i == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o = rx_ready;
  assign mem.req    = req;
  assign mem.we     = req;
  assign mem.addr   = addr_q;
  assign mem.data   = data_buf;
  assign mem.sel    = sel_buf;
  assign halt_o     = (state != IDLE);
  assign busy_o     = (state != IDLE);
  assign done_o     = done;
  assign err_o      = err;

endmodule
